// File: rtl/fp_mult_pipe.sv
// Parametrised 3-stage floating-point multiplier (default IEEE-754 single precision).
// Valid/ready handshake, round-to-nearest-even, flush-to-zero, {invalid, overflow, underflow}.
module fp_mult_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] dataa,
    input  logic [EXP_W+MAN_W:0] datab,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [2:0]           flags
);
    localparam int unsigned W  = 1 + EXP_W + MAN_W;
    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned SW = MAN_W + 1;
    localparam int unsigned PW = 2 * MAN_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [1:0] {KNorm, KZero, KInf, KNan} kind_e;

    logic                 en;
    logic                 v1_q, v1_d, s1_q, s1_d, inv1_q, inv1_d;
    kind_e                k1_q, k1_d;
    logic signed [EW-1:0] e1_q, e1_d;
    logic [SW-1:0]        ma1_q, ma1_d, mb1_q, mb1_d;
    logic                 v2_q, v2_d, s2_q, s2_d, inv2_q, inv2_d;
    kind_e                k2_q, k2_d;
    logic signed [EW-1:0] e2_q, e2_d;
    logic [PW-1:0]        p2_q, p2_d;
    logic                 v3_q, v3_d;
    logic [W-1:0]         res_q, res_d;
    logic [2:0]           flg_q, flg_d;

    // One global enable: the whole pipe advances or the whole pipe holds.
    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;
    assign result    = res_q;
    assign flags     = flg_q;

    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             za, zb, ia, ib, na, nb, inv_in;
    kind_e            kind_in;

    assign {sa, ea, fa} = dataa;
    assign {sb, eb, fb} = datab;

    always_comb begin
        za      = (ea == '0);
        zb      = (eb == '0);
        ia      = (ea == '1) && (fa == '0);
        ib      = (eb == '1) && (fb == '0);
        na      = (ea == '1) && (fa != '0);
        nb      = (eb == '1) && (fb != '0);
        inv_in  = (ia && zb) || (za && ib);
        kind_in = KNorm;
        if (na || nb || inv_in) kind_in = KNan;
        else if (ia || ib)      kind_in = KInf;
        else if (za || zb)      kind_in = KZero;
    end

    logic [PW-2:0]        pn;
    logic [SW:0]          sig;
    logic                 guard, sticky, inc, carry;
    logic signed [EW-1:0] e3;
    logic [MAN_W-1:0]     frac3;
    logic [W-1:0]         res_n;
    logic [2:0]           flg_n;

    // Normalise so the hidden bit sits at pn[2*MAN_W]; a bit shifted out joins sticky.
    always_comb begin
        pn     = p2_q[PW-1] ? p2_q[PW-1:1] : p2_q[PW-2:0];
        guard  = pn[MAN_W-1];
        sticky = (|pn[MAN_W-2:0]) || (p2_q[PW-1] && p2_q[0]);
        inc    = guard && (sticky || pn[MAN_W]);
        sig    = {1'b0, pn[PW-2 -: SW]} + (SW + 1)'(inc);
        carry  = sig[SW];
        frac3  = carry ? sig[SW-1:1] : sig[SW-2:0];
        e3     = e2_q + $signed(EW'(p2_q[PW-1])) + $signed(EW'(carry));
        res_n  = '0;
        flg_n  = '0;
        case (k2_q)
            KNan: begin
                res_n = QNAN;
                flg_n = {inv2_q, 2'b00};
            end
            KInf:  res_n = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            KZero: res_n = {s2_q, {(W - 1){1'b0}}};
            default: begin
                if (e3 >= EMAX) begin
                    res_n = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flg_n = 3'b010;
                end else if (e3 <= 0) begin
                    res_n = {s2_q, {(W - 1){1'b0}}};
                    flg_n = 3'b001;
                end else begin
                    res_n = {s2_q, e3[EXP_W-1:0], frac3};
                end
            end
        endcase
    end

    always_comb begin
        v1_d   = v1_q;
        s1_d   = s1_q;
        inv1_d = inv1_q;
        k1_d   = k1_q;
        e1_d   = e1_q;
        ma1_d  = ma1_q;
        mb1_d  = mb1_q;
        v2_d   = v2_q;
        s2_d   = s2_q;
        inv2_d = inv2_q;
        k2_d   = k2_q;
        e2_d   = e2_q;
        p2_d   = p2_q;
        v3_d   = v3_q;
        res_d  = res_q;
        flg_d  = flg_q;
        if (en) begin
            v1_d   = in_valid;
            s1_d   = sa ^ sb;
            inv1_d = inv_in;
            k1_d   = kind_in;
            e1_d   = $signed(EW'(ea)) + $signed(EW'(eb)) - BIAS;
            ma1_d  = {1'b1, fa};
            mb1_d  = {1'b1, fb};
            v2_d   = v1_q;
            s2_d   = s1_q;
            inv2_d = inv1_q;
            k2_d   = k1_q;
            e2_d   = e1_q;
            p2_d   = PW'(ma1_q) * PW'(mb1_q);
            v3_d   = v2_q;
            // Bubbles load zeros so result/flags read 0 whenever nothing is valid.
            res_d  = v2_q ? res_n : '0;
            flg_d  = v2_q ? flg_n : '0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            inv1_q <= 1'b0;
            k1_q   <= KNorm;
            e1_q   <= '0;
            ma1_q  <= '0;
            mb1_q  <= '0;
            v2_q   <= 1'b0;
            s2_q   <= 1'b0;
            inv2_q <= 1'b0;
            k2_q   <= KNorm;
            e2_q   <= '0;
            p2_q   <= '0;
            v3_q   <= 1'b0;
            res_q  <= '0;
            flg_q  <= '0;
        end else begin
            v1_q   <= v1_d;
            s1_q   <= s1_d;
            inv1_q <= inv1_d;
            k1_q   <= k1_d;
            e1_q   <= e1_d;
            ma1_q  <= ma1_d;
            mb1_q  <= mb1_d;
            v2_q   <= v2_d;
            s2_q   <= s2_d;
            inv2_q <= inv2_d;
            k2_q   <= k2_d;
            e2_q   <= e2_d;
            p2_q   <= p2_d;
            v3_q   <= v3_d;
            res_q  <= res_d;
            flg_q  <= flg_d;
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: single-precision instance under random backpressure
// plus a half-precision instance, both checked against an integer-arithmetic model.
module tb_fp_mult_pipe;
    logic        clock = 1'b0;
    logic        resetn, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] dataa, datab, result;
    logic [2:0]  flags;
    logic        hin_valid, hin_ready, hout_valid, hout_ready;
    logic [15:0] hdataa, hdatab, hresult;
    logic [2:0]  hflags;
    int          errors = 0;
    int          checks = 0;
    logic [34:0] exp_q[$];
    logic        rand_done;

    fp_mult_pipe dut (
        .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clock(clock), .resetn(resetn), .in_valid(hin_valid), .in_ready(hin_ready),
        .dataa(hdataa), .datab(hdatab), .out_valid(hout_valid), .out_ready(hout_ready),
        .result(hresult), .flags(hflags)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: exact integer product, then IEEE rounding by remainder comparison.
    function automatic logic [34:0] ref_mul(input int ew, input int mw,
                                            input logic [31:0] a, input logic [31:0] b);
        longint unsigned emask, fmask, ea, eb, fa, fb, p, q, rem, half, sgn;
        longint e;
        int k, sh;
        logic za, zb, ia, ib, na, nb, inv;
        emask = (64'd1 << ew) - 1;
        fmask = (64'd1 << mw) - 1;
        ea = (64'(a) >> mw) & emask;
        eb = (64'(b) >> mw) & emask;
        fa = 64'(a) & fmask;
        fb = 64'(b) & fmask;
        sgn = 64'(a[ew+mw] ^ b[ew+mw]) << (ew + mw);
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == emask) && (fa == 0);
        ib = (eb == emask) && (fb == 0);
        na = (ea == emask) && (fa != 0);
        nb = (eb == emask) && (fb != 0);
        inv = (ia && zb) || (za && ib);
        if (na || nb || inv) return {inv, 2'b00, 32'((emask << mw) | (64'd1 << (mw - 1)))};
        if (ia || ib) return {3'b000, 32'(sgn | (emask << mw))};
        if (za || zb) return {3'b000, 32'(sgn)};
        p = (fa | (64'd1 << mw)) * (fb | (64'd1 << mw));
        k = 0;
        for (int i = 0; i < 64; i++) if (p[i]) k = i;
        e = longint'(ea) + longint'(eb) - ((longint'(1) << (ew - 1)) - 1) + longint'(k - 2 * mw);
        sh = k - mw;
        q = p >> sh;
        rem = p & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if ((q >> (mw + 1)) != 0) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= longint'(emask)) return {3'b010, 32'(sgn | (emask << mw))};
        if (e <= 0) return {3'b001, 32'(sgn)};
        return {3'b000, 32'(sgn | ($unsigned(e) << mw) | (q & fmask))};
    endfunction

    function automatic logic [31:0] rand_f32();
        int r;
        logic [7:0] e;
        logic [22:0] f;
        r = $urandom_range(0, 19);
        f = 23'($urandom);
        if (r == 0) e = 8'd0;
        else if (r == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 0) f = '0;
        end
        else if (r == 2) e = 8'($urandom_range(1, 40));
        else if (r == 3) e = 8'($urandom_range(215, 254));
        else e = 8'($urandom_range(100, 154));
        if (r == 4) f = 23'h7FFFFF - 23'($urandom_range(0, 3));
        return {1'($urandom), e, f};
    endfunction

    function automatic logic [15:0] rand_f16();
        int r;
        logic [4:0] e;
        logic [9:0] f;
        r = $urandom_range(0, 19);
        f = 10'($urandom);
        if (r == 0) e = 5'd0;
        else if (r == 1) begin
            e = 5'h1F;
            if ($urandom_range(0, 1) == 0) f = '0;
        end
        else if (r == 2) e = 5'($urandom_range(1, 6));
        else if (r == 3) e = 5'($urandom_range(25, 30));
        else e = 5'($urandom_range(10, 20));
        if (r == 4) f = 10'h3FF - 10'($urandom_range(0, 3));
        return {1'($urandom), e, f};
    endfunction

    // Drive operands at negedge; once in_ready is seen the expectation is queued.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [34:0] e);
        int n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        dataa = a;
        datab = b;
        #2;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            #2;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (3) @(negedge clock);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic hsend(input logic [15:0] a, input logic [15:0] b, input logic [34:0] e,
                         input string name);
        int n = 0;
        @(negedge clock);
        hin_valid = 1'b1;
        hdataa = a;
        hdatab = b;
        #2 check("h_in_ready", 64'(hin_ready), 64'd1);
        @(posedge clock);
        #1 hin_valid = 1'b0;
        @(negedge clock);
        #1;
        while (!hout_valid && n < 10) begin
            @(negedge clock);
            #1;
            n++;
        end
        check(name, {45'd0, hout_valid, hflags, hresult}, {45'd0, 1'b1, e[34:32], e[15:0]});
    endtask

    initial begin : monitor
        logic        held_v;
        logic [34:0] held, exp_v;
        held_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clock);
            #1;
            if (!resetn) begin
                held_v = 1'b0;
            end else begin
                if (held_v) check("stall_hold", 64'({flags, result}), 64'(held));
                held_v = 1'b0;
                if (out_valid && !out_ready) begin
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    held = {flags, result};
                    held_v = 1'b1;
                end else if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got %h with no pending request",
                                 {flags, result});
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("result", 64'({flags, result}), 64'(exp_v));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, b;
        logic [15:0] ha, hb;
        int lat;
        resetn = 1'b0;
        in_valid = 1'b0;
        dataa = '0;
        datab = '0;
        out_ready = 1'b1;
        hin_valid = 1'b0;
        hdataa = '0;
        hdatab = '0;
        hout_ready = 1'b1;
        rand_done = 1'b0;
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        send(32'h40000000, 32'h40400000, {3'b000, 32'h40C00000});
        lat = 1;
        @(negedge clock);
        #2;
        while (!out_valid && lat < 20) begin
            lat++;
            @(negedge clock);
            #2;
        end
        check("latency", 64'(lat), 64'd3);

        send(32'h3FC00000, 32'h3FC00000, {3'b000, 32'h40100000});
        send(32'h3F800001, 32'h3F800001, {3'b000, 32'h3F800002});
        send(32'hBF800000, 32'h3F800000, {3'b000, 32'hBF800000});
        send(32'h7F800000, 32'h00000000, {3'b100, 32'h7FC00000});
        send(32'hFF800000, 32'h40000000, {3'b000, 32'hFF800000});
        send(32'h7FC00001, 32'h3F800000, {3'b000, 32'h7FC00000});
        send(32'h00000001, 32'h3F800000, {3'b000, 32'h00000000});
        send(32'h7F000000, 32'h7F000000, {3'b010, 32'h7F800000});
        send(32'h00800000, 32'h00800000, {3'b001, 32'h00000000});
        drain();

        // Five back-to-back operations with the consumer stalled mid-stream.
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    a = rand_f32();
                    b = rand_f32();
                    send(a, b, ref_mul(8, 23, a, b));
                end
            end
            begin
                repeat (4) @(negedge clock);
                out_ready = 1'b0;
                repeat (5) @(negedge clock);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three operations in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = rand_f32();
            b = rand_f32();
            send(a, b, ref_mul(8, 23, a, b));
        end
        @(negedge clock);
        #3 resetn = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'd0);
        check("midreset_result", 64'(result), 64'd0);
        check("midreset_flags", 64'(flags), 64'd0);
        check("midreset_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clock);
        #2 check("post_reset_idle", 64'(out_valid), 64'd0);

        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    a = rand_f32();
                    b = rand_f32();
                    send(a, b, ref_mul(8, 23, a, b));
                    repeat ($urandom_range(0, 2)) @(posedge clock);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clock);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        hsend(16'h4000, 16'h4200, {3'b000, 32'h00004600}, "half_2x3");
        for (int i = 0; i < 40; i++) begin
            ha = rand_f16();
            hb = rand_f16();
            hsend(ha, hb, ref_mul(5, 10, {16'd0, ha}, {16'd0, hb}), "half_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
